set_assoc_wb_cache: RTL and testbench

SET_ASSOC_WB_CACHE -- requirements
Module: set_assoc_wb_cache

---
 rtl/set_assoc_wb_cache.sv | 260 ++++++++++++++++++++++++++
 tb/tb_set_assoc_wb_cache.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_wb_cache.sv
// set_assoc_wb_cache: WAYS-way set-associative, write-back, write-allocate cache
// sitting between a single-word CPU port and a block-wide memory port.
//
// Ports
//   clk, reset           rising-edge clock; asynchronous active-high reset
//   cpu_req              request valid (accepted only when idle)
//   cpu_address          byte address, bits [1:0] ignored
//   read_write           0 read, 1 write
//   cpu_write_data       full-word write data
//   cpu_read_data        read data, valid with cpu_ready
//   cpu_ready            one-cycle completion pulse
//   hit_miss             1 when the access hit on its first lookup
//   dm_req               memory transfer request (held until dm_ready)
//   dm_read_write        0 block read (fill), 1 block write (victim writeback)
//   dm_address           block-aligned memory address
//   dm_write_data        victim block, word 0 in bits [31:0]
//   dm_read_data         fill block
//   dm_ready             memory transfer complete pulse
//   hit_count/miss_count completed-access counters, saturating at 0xFFFF
//                        (present only with CACHE_STATS_EN defined)
//
// Optional feature macro: CACHE_STATS_EN
`timescale 1ns/1ps
module set_assoc_wb_cache #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 4,
    parameter int unsigned WPB    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic                read_write,
    input  logic [31:0]         cpu_write_data,
    output logic [31:0]         cpu_read_data,
    output logic                cpu_ready,
    output logic                hit_miss,
    output logic                dm_req,
    output logic                dm_read_write,
    output logic [ADDR_W-1:0]   dm_address,
    output logic [32*WPB-1:0]   dm_write_data,
    input  logic [32*WPB-1:0]   dm_read_data,
    input  logic                dm_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);

    localparam int unsigned OFF_W = $clog2(WPB);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
    localparam int unsigned AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned WAY_W = AGE_W;

    typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StAllocate} state_e;

    state_e              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rw;
    logic [31:0]         r_wdata;
    logic                r_missed;
    logic [WAY_W-1:0]    r_victim;

    logic [32*WPB-1:0]   r_data  [WAYS][SETS];
    logic [TAG_W-1:0]    r_tag   [WAYS][SETS];
    logic [AGE_W-1:0]    r_age   [WAYS][SETS];
    logic [WAYS-1:0]     r_valid [SETS];
    logic [WAYS-1:0]     r_dirty [SETS];

    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_idx;
    logic [OFF_W-1:0]    w_off;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic [WAY_W-1:0]    w_victim;
    logic                w_inv_found;
    logic [WAY_W-1:0]    w_lru;
    logic [31:0]         w_hit_word;
    logic                w_hit_upd;
    logic                w_fill;
    logic                w_unused_addr;

    assign w_tag         = r_addr[ADDR_W-1 -: TAG_W];
    assign w_idx         = r_addr[2+OFF_W +: IDX_W];
    assign w_off         = r_addr[2 +: OFF_W];
    assign w_unused_addr = ^r_addr[1:0];

    // Tag lookup and victim choice for the latched request's set.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_lru       = '0;
        w_victim    = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (r_age[w][w_idx] == AGE_W'(WAYS - 1)) begin
                w_lru = WAY_W'(w);
            end
        end
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!r_valid[w_idx][w] && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_victim    = WAY_W'(w);
            end
        end
        if (!w_inv_found) begin
            w_victim = w_lru;
        end
    end

    assign w_hit_word = r_data[w_hit_way][w_idx][{w_off, 5'b0} +: 32];
    assign w_hit_upd  = (r_state == StCompare) && w_hit;
    assign w_fill     = (r_state == StAllocate) && dm_ready;

    // Next state and outputs; outputs are all zero in idle, so the
    // asynchronous reset of r_state zeroes them immediately.
    always_comb begin
        w_state_next  = r_state;
        cpu_ready     = 1'b0;
        hit_miss      = 1'b0;
        cpu_read_data = '0;
        dm_req        = 1'b0;
        dm_read_write = 1'b0;
        dm_address    = '0;
        dm_write_data = '0;
        case (r_state)
            StIdle: begin
                if (cpu_req) begin
                    w_state_next = StCompare;
                end
            end
            StCompare: begin
                if (w_hit) begin
                    cpu_ready    = 1'b1;
                    hit_miss     = ~r_missed;
                    w_state_next = StIdle;
                    if (!r_rw) begin
                        cpu_read_data = w_hit_word;
                    end
                end else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) begin
                    w_state_next = StWriteback;
                end else begin
                    w_state_next = StAllocate;
                end
            end
            StWriteback: begin
                dm_req        = 1'b1;
                dm_read_write = 1'b1;
                dm_address    = {r_tag[r_victim][w_idx], w_idx, {(OFF_W + 2){1'b0}}};
                dm_write_data = r_data[r_victim][w_idx];
                if (dm_ready) begin
                    w_state_next = StAllocate;
                end
            end
            StAllocate: begin
                dm_req     = 1'b1;
                dm_address = {w_tag, w_idx, {(OFF_W + 2){1'b0}}};
                if (dm_ready) begin
                    w_state_next = StCompare;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_addr   <= '0;
            r_rw     <= 1'b0;
            r_wdata  <= '0;
            r_missed <= 1'b0;
            r_victim <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == StIdle) && cpu_req) begin
                r_addr   <= cpu_address;
                r_rw     <= read_write;
                r_wdata  <= cpu_write_data;
                r_missed <= 1'b0;
            end
            // Victim is frozen here: filling it changes what the lookup would pick.
            if ((r_state == StCompare) && !w_hit) begin
                r_missed <= 1'b1;
                r_victim <= w_victim;
            end
        end
    end

    // Line state: valid/dirty/age. Ages form a per-set permutation, oldest = LRU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    r_age[w][s] <= AGE_W'(w);
                end
            end
        end else begin
            if (w_hit_upd) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == w_hit_way) begin
                        r_age[w][w_idx] <= '0;
                    end else if (r_age[w][w_idx] < r_age[w_hit_way][w_idx]) begin
                        r_age[w][w_idx] <= r_age[w][w_idx] + 1'b1;
                    end
                end
                if (r_rw) begin
                    r_dirty[w_idx][w_hit_way] <= 1'b1;
                end
            end
            if (w_fill) begin
                r_valid[w_idx][r_victim] <= 1'b1;
                r_dirty[w_idx][r_victim] <= 1'b0;
            end
        end
    end

    // Data and tag arrays carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_data[r_victim][w_idx] <= dm_read_data;
            r_tag[r_victim][w_idx]  <= w_tag;
        end else if (w_hit_upd && r_rw) begin
            r_data[w_hit_way][w_idx][{w_off, 5'b0} +: 32] <= r_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (cpu_ready) begin
            if (hit_miss) begin
                if (r_hit_count != 16'hFFFF) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end else if (r_miss_count != 16'hFFFF) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_set_assoc_wb_cache.sv
// Self-checking bench for set_assoc_wb_cache (default parameters).
// Reference model: per-set recency lists (MRU first) plus a reference memory.
`timescale 1ns/1ps
module tb_set_assoc_wb_cache;

    localparam int ADDR_W = 10;
    localparam int WAYS   = 2;
    localparam int SETS   = 4;
    localparam int WPB    = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               cpu_req;
    logic [ADDR_W-1:0]  cpu_address;
    logic               read_write;
    logic [31:0]        cpu_write_data;
    logic [31:0]        cpu_read_data;
    logic               cpu_ready;
    logic               hit_miss;
    logic               dm_req;
    logic               dm_read_write;
    logic [ADDR_W-1:0]  dm_address;
    logic [32*WPB-1:0]  dm_write_data;
    logic [32*WPB-1:0]  dm_read_data;
    logic               dm_ready;
`ifdef CACHE_STATS_EN
    logic [15:0]        hit_count;
    logic [15:0]        miss_count;
`endif

    always #5 clk = ~clk;

    set_assoc_wb_cache #(
        .ADDR_W(ADDR_W),
        .WAYS  (WAYS),
        .SETS  (SETS),
        .WPB   (WPB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_address   (cpu_address),
        .read_write    (read_write),
        .cpu_write_data(cpu_write_data),
        .cpu_read_data (cpu_read_data),
        .cpu_ready     (cpu_ready),
        .hit_miss      (hit_miss),
        .dm_req        (dm_req),
        .dm_read_write (dm_read_write),
        .dm_address    (dm_address),
        .dm_write_data (dm_write_data),
        .dm_read_data  (dm_read_data),
        .dm_ready      (dm_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    typedef struct packed {
        logic [3:0]   tag;
        logic         dirty;
        logic [127:0] data;
    } line_t;

    typedef struct packed {
        logic         rw;
        logic [9:0]   addr;
        logic [127:0] data;
    } xfer_t;

    line_t        cset [SETS][$];
    xfer_t        exp_q[$];
    logic [31:0]  mem     [256];
    logic [31:0]  ref_mem [256];

    int n_checks = 0;
    int n_fails  = 0;

    // Last observed writeback, for the directed checks.
    logic [9:0]   last_wb_addr;
    logic [127:0] last_wb_data;
    int           n_wb_seen;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) cset[s].delete();
    endtask

    task automatic access(input logic rw, input logic [9:0] addr, input logic [31:0] wd,
                          output logic obs_hit);
        logic [3:0]   tag;
        logic [1:0]   idx;
        logic [1:0]   off;
        int           pos;
        int           n_exp;
        int           nx;
        int           wait_cnt;
        bit           done;
        bit           exp_hit;
        line_t        ln;
        xfer_t        e;
        logic [31:0]  exp_rd;
        logic [7:0]   wbase;

        tag = addr[9:6];
        idx = addr[5:4];
        off = addr[3:2];
        pos = -1;
        exp_q.delete();
        for (int i = 0; i < cset[idx].size(); i++) if (cset[idx][i].tag == tag) pos = i;
        exp_hit = (pos >= 0);
        if (exp_hit) begin
            ln = cset[idx][pos];
            cset[idx].delete(pos);
        end else begin
            if (cset[idx].size() == WAYS) begin
                ln = cset[idx].pop_back();
                if (ln.dirty) begin
                    e.rw   = 1'b1;
                    e.addr = {ln.tag, idx, 4'b0};
                    e.data = ln.data;
                    exp_q.push_back(e);
                    wbase  = {ln.tag, idx, 2'b0};
                    for (int k = 0; k < WPB; k++) ref_mem[int'(wbase) + k] = ln.data[k*32 +: 32];
                end
            end
            e.rw   = 1'b0;
            e.addr = {tag, idx, 4'b0};
            e.data = '0;
            exp_q.push_back(e);
            wbase    = {tag, idx, 2'b0};
            ln.tag   = tag;
            ln.dirty = 1'b0;
            for (int k = 0; k < WPB; k++) ln.data[k*32 +: 32] = ref_mem[int'(wbase) + k];
        end
        exp_rd = ln.data[{off, 5'b0} +: 32];
        if (rw) begin
            ln.data[{off, 5'b0} +: 32] = wd;
            ln.dirty = 1'b1;
        end
        cset[idx].push_front(ln);
        n_exp = exp_q.size();

        @(negedge clk);
        cpu_req        = 1'b1;
        cpu_address    = addr;
        read_write     = rw;
        cpu_write_data = wd;
        @(negedge clk);
        cpu_req        = 1'b0;
        cpu_address    = 10'($urandom);
        read_write     = 1'($urandom);
        cpu_write_data = $urandom;
        done     = 1'b0;
        nx       = 0;
        wait_cnt = -1;
        obs_hit  = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            dm_ready = 1'b0;
            if (cpu_ready) begin
                done    = 1'b1;
                obs_hit = hit_miss;
                check_eq("hit_miss", hit_miss, exp_hit);
                if (!rw) check_eq("read_data", cpu_read_data, exp_rd);
                if (exp_hit) check_eq("hit_latency", cyc, 0);
                check_eq("xfer_count", nx, n_exp);
                check_eq("dm_req_at_ready", dm_req, 1'b0);
            end else if (dm_req) begin
                if (wait_cnt < 0) begin
                    nx++;
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("dm_read_write", dm_read_write, e.rw);
                        check_eq("dm_address", dm_address, e.addr);
                        if (e.rw) check_eq("dm_write_data", dm_write_data, e.data);
                    end
                    if (dm_read_write) begin
                        last_wb_addr = dm_address;
                        last_wb_data = dm_write_data;
                        n_wb_seen++;
                    end
                    wait_cnt = $urandom_range(0, 2);
                end
                if (wait_cnt == 0) begin
                    wbase = dm_address[9:2];
                    if (dm_read_write) begin
                        for (int k = 0; k < WPB; k++) mem[int'(wbase) + k] = dm_write_data[k*32 +: 32];
                    end else begin
                        for (int k = 0; k < WPB; k++) dm_read_data[k*32 +: 32] = mem[int'(wbase) + k];
                    end
                    dm_ready = 1'b1;
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
        if (!done) begin
            check_eq("access_timeout", done, 1'b1);
            dm_ready = 1'b0;
        end
    endtask

    logic h;
    int   wb_before;
    bit   seen;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i * 4);
            ref_mem[i] = 32'(i * 4);
        end
        n_wb_seen      = 0;
        reset          = 1'b1;
        cpu_req        = 1'b0;
        cpu_address    = '0;
        read_write     = 1'b0;
        cpu_write_data = '0;
        dm_read_data   = '0;
        dm_ready       = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_eq("rst_cpu_ready", cpu_ready, 1'b0);
        check_eq("rst_hit_miss", hit_miss, 1'b0);
        check_eq("rst_read_data", cpu_read_data, 32'h0);
        check_eq("rst_dm_req", dm_req, 1'b0);
        check_eq("rst_dm_addr", dm_address, 10'h0);
        check_eq("rst_dm_wdata", dm_write_data, 128'h0);
        reset = 1'b0;

        // Directed sequence: cold miss, write-back hits, retention, eviction.
        access(1'b0, 10'h000, 32'h0, h);
        check_eq("cold_read_miss", h, 1'b0);
        access(1'b1, 10'h000, 32'h0000_00FF, h);
        check_eq("write_hit", h, 1'b1);
        access(1'b0, 10'h000, 32'h0, h);
        check_eq("read_after_write_hit", h, 1'b1);
        check_eq("mem0_unwritten", mem[0], 32'h0);
        access(1'b0, 10'h200, 32'h0, h);
        check_eq("read200_miss", h, 1'b0);
        access(1'b0, 10'h000, 32'h0, h);
        check_eq("two_way_retention", h, 1'b1);
        wb_before = n_wb_seen;
        access(1'b0, 10'h300, 32'h0, h);
        check_eq("read300_miss", h, 1'b0);
        check_eq("clean_evict_no_wb", n_wb_seen, wb_before);
        access(1'b0, 10'h200, 32'h0, h);
        check_eq("read200_remiss", h, 1'b0);
        check_eq("wb_count", n_wb_seen, wb_before + 1);
        check_eq("wb_addr", last_wb_addr, 10'h000);
        check_eq("wb_word0", last_wb_data[31:0], 32'h0000_00FF);
`ifdef CACHE_STATS_EN
        check_eq("hit_count", hit_count, 16'd3);
        check_eq("miss_count", miss_count, 16'd4);
`endif

        // Reset during an allocate abandons the transfer.
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_address = 10'h030;
        read_write  = 1'b0;
        @(negedge clk);
        cpu_req = 1'b0;
        seen    = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            if (dm_req && !dm_read_write) seen = 1'b1;
            else @(negedge clk);
        end
        check_eq("alloc_seen", seen, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_dm_req", dm_req, 1'b0);
        check_eq("async_rst_dm_addr", dm_address, 10'h0);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        access(1'b0, 10'h000, 32'h0, h);
        check_eq("post_reset_miss", h, 1'b0);
`ifdef CACHE_STATS_EN
        check_eq("post_reset_miss_count", miss_count, 16'd1);
`endif

        // Randomised traffic over two sets with a small tag pool.
        for (int n = 0; n < 400; n++) begin
            logic [9:0] a;
            a = {4'($urandom_range(0, 5)), 2'($urandom_range(0, 1)), 2'($urandom), 2'($urandom)};
            access(1'($urandom), a, $urandom, h);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
